// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (icache / dcache) arbiter in front of one memory bus.
// A single registered FSM (IDLE, GNT_I, GNT_D) picks a requester when IDLE,
// then forwards the granted port's address/data/control straight through to
// the memory side until m_ack or until the requester withdraws its strobe.
// There is always at least one IDLE cycle between two grants.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, a simultaneous request goes to the
//                            port that did not win last time (first tie after
//                            reset goes to I). When undefined, ties always go
//                            to D. The last-grant register is kept either way.

module mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    // icache miss port (read only)
    input  logic         i_stb,
    input  logic [11:0]  i_adr,
    output logic         i_ack,
    output logic [127:0] i_dat_s,

    // dcache port (read or writeback)
    input  logic         d_stb,
    input  logic         d_we,
    input  logic [11:0]  d_adr,
    input  logic [127:0] d_dat_m,
    input  logic [15:0]  d_sel,
    output logic         d_ack,
    output logic [127:0] d_dat_s,

    // memory side
    output logic         m_cyc,
    output logic         m_stb,
    output logic         m_we,
    output logic [11:0]  m_adr,
    output logic [127:0] m_dat_m,
    output logic [15:0]  m_sel,
    input  logic         m_ack,
    input  logic [127:0] m_dat_s
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    // Encoding of the last-grant register.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   last_grant_nxt;
    logic   tie_to_d;

    // Tie-break policy: decides who wins when both strobes are high in IDLE.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_to_d = (last_grant == LAST_I);
`else
    assign tie_to_d = 1'b1;
`endif

    // State and last-grant registers; reset aborts any transfer in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= LAST_D;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, leave a grant on m_ack or withdrawal.
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                // m_ack seen here is spurious and deliberately ignored.
                if (i_stb && d_stb) begin
                    if (tie_to_d) begin
                        state_nxt      = GNT_D;
                        last_grant_nxt = LAST_D;
                    end else begin
                        state_nxt      = GNT_I;
                        last_grant_nxt = LAST_I;
                    end
                end else if (i_stb) begin
                    state_nxt      = GNT_I;
                    last_grant_nxt = LAST_I;
                end else if (d_stb) begin
                    state_nxt      = GNT_D;
                    last_grant_nxt = LAST_D;
                end
            end
            GNT_I: begin
                if (!i_stb || m_ack) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (!d_stb || m_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory-side mux and ack steering; a withdrawn strobe kills the cycle
    // (and any coincident m_ack) in the same clock.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_adr   = '0;
        m_dat_m = '0;
        m_sel   = '0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        case (state)
            GNT_I: begin
                // Instruction fetches are always full-line reads.
                m_adr = i_adr;
                m_sel = 16'hFFFF;
                if (i_stb) begin
                    m_cyc = 1'b1;
                    m_stb = 1'b1;
                    i_ack = m_ack;
                end
            end
            GNT_D: begin
                m_we    = d_we;
                m_adr   = d_adr;
                m_dat_m = d_dat_m;
                m_sel   = d_sel;
                if (d_stb) begin
                    m_cyc = 1'b1;
                    m_stb = 1'b1;
                    d_ack = m_ack;
                end
            end
            default: begin
                // IDLE: memory bus quiet, no acks.
            end
        endcase
    end

    // Read data fans out to both ports; only the acked port consumes it.
    // Held at zero while reset is asserted so all outputs are quiet.
    assign i_dat_s = rst_n ? m_dat_s : '0;
    assign d_dat_s = rst_n ? m_dat_s : '0;

endmodule
